// File: rtl/iter_mac_pkg.sv
// ============================================================================
// Package : iter_mac_pkg
// Purpose : Shared definitions for the iterative DSP multiply-accumulate unit:
//           FSM state encodings, the mode-bit index and helper functions for
//           chunk counts and counter widths.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package iter_mac_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit of the mode input selecting signed (1) / unsigned (0) operation
    localparam int MODE_SIGNED = 0;

    // Number of W-bit chunks in an operand of the given width
    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Counter width able to index n chunks (never narrower than one bit)
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/iter_mac_chunk_mult.sv
// ============================================================================
// Module  : iter_mac_chunk_mult
// Purpose : Purely combinational (W+1)x(W+1) signed sub-multiplier. PPM selects
//           the partial-product tree flavour (0 = wallace, 1 = dadda); both
//           trees feed the final addition with no pipeline stages.
// Ports   : x, y  in  W+1    signed chunk operands
//           p     out 2W+2   signed product
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_mac_chunk_mult #(
    parameter int W   = 8,
    parameter int PPM = 0
) (
    input  logic signed [W:0]     x,
    input  logic signed [W:0]     y,
    output logic signed [2*W+1:0] p
);

    // Operands are widened to the product width first so the multiply is
    // carried out at full precision with sign extension.
    generate
        if (PPM == 1) begin : g_dadda
            assign p = (2*W+2)'(x) * (2*W+2)'(y);
        end else begin : g_wallace
            assign p = (2*W+2)'(x) * (2*W+2)'(y);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/iter_mac.sv
// ============================================================================
// Module  : iter_mac
// Purpose : Iterative multiply-accumulate. a is split into KA=N/W chunks and b
//           into KB=M/W chunks; one (W+1)x(W+1) signed partial product per
//           cycle is shifted into a guarded ACC_W=N+M+G bit accumulator.
//           Optional macro ITER_MAC_SAT_EN enables saturating accumulation
//           with a sticky per-operation overflow flag; without it the
//           accumulator wraps and ovf stays 0.
// Ports   : clk, reset_n (async active-low)
//           in_valid/in_ready       operand handshake
//           a[N], b[M], c[ACC_W]    operands and addend (c used when mac=0)
//           mode[2]                 bit0 signed, bit1 reserved
//           mac                     accumulate onto previous result
//           out_valid, out, ovf     one-cycle result strobe, held result, flag
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module iter_mac
    import iter_mac_pkg::*;
#(
    parameter int N   = 16,
    parameter int M   = 16,
    parameter int W   = 8,
    parameter int G   = 4,
    parameter int PPM = 0,
    localparam int ACC_W = N + M + G
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [M-1:0]     b,
    input  logic [ACC_W-1:0] c,
    input  logic [1:0]       mode,
    input  logic             mac,
    output logic             out_valid,
    output logic [ACC_W-1:0] out,
    output logic             ovf
);

    localparam int KA = num_chunks(N, W);
    localparam int KB = num_chunks(M, W);
    localparam int IW = cnt_width(KA);
    localparam int JW = cnt_width(KB);

    logic [1:0]        state;
    logic [N-1:0]      a_r;
    logic [M-1:0]      b_r;
    logic              sgn_r;
    logic [IW-1:0]     i_cnt;
    logic [JW-1:0]     j_cnt;
    logic [ACC_W-1:0]  acc;
    logic              ovf_run;

    logic              accept;
    logic [N-1:0]      a_sh;
    logic [M-1:0]      b_sh;
    logic              a_top;
    logic              b_top;
    logic signed [W:0] a_ext;
    logic signed [W:0] b_ext;
    logic signed [2*W+1:0]     pp;
    logic signed [ACC_W-1:0]   pp_ext;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_next;
    logic              last_i;
    logic              last_j;
    logic              unused_mode;

    assign unused_mode = mode[1];

    assign in_ready = (state != ST_RUN);
    assign accept   = in_valid & in_ready;

    // Chunk selection: only the most significant chunk carries the sign.
    assign a_sh  = a_r >> (32'(i_cnt) * W);
    assign b_sh  = b_r >> (32'(j_cnt) * W);
    assign a_top = (i_cnt == IW'(KA - 1));
    assign b_top = (j_cnt == JW'(KB - 1));
    assign a_ext = {sgn_r & a_top & a_sh[W-1], a_sh[W-1:0]};
    assign b_ext = {sgn_r & b_top & b_sh[W-1], b_sh[W-1:0]};

    iter_mac_chunk_mult #(
        .W   (W),
        .PPM (PPM)
    ) u_chunk_mult (
        .x (a_ext),
        .y (b_ext),
        .p (pp)
    );

    // Sign-extend the product to the accumulator width, then align it.
    assign pp_ext = ACC_W'(pp);
    assign addend = pp_ext << ((32'(i_cnt) + 32'(j_cnt)) * W);

`ifdef ITER_MAC_SAT_EN
    logic [ACC_W:0] sum;
    logic           step_ovf;

    always_comb begin
        sum      = {sgn_r & acc[ACC_W-1], acc} + {sgn_r & addend[ACC_W-1], addend};
        // Signed: the two top bits of the widened sum disagree.
        // Unsigned: any carry out of the accumulator width.
        step_ovf = sgn_r ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
        acc_next = sum[ACC_W-1:0];
        if (ovf_run) begin
            acc_next = acc;                       // already clamped: hold
        end else if (step_ovf) begin
            if (!sgn_r)
                acc_next = {ACC_W{1'b1}};
            else if (sum[ACC_W])
                acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            else
                acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
        ovf_next = ovf_run | step_ovf;
    end
`else
    assign acc_next = acc + addend;
    // ovf_run is cleared at every accept, so this is constantly 0.
    assign ovf_next = ovf_run;
`endif

    assign last_i = (i_cnt == IW'(KA - 1));
    assign last_j = (j_cnt == JW'(KB - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sgn_r     <= 1'b0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            acc       <= '0;
            ovf_run   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_RUN: begin
                    acc     <= acc_next;
                    ovf_run <= ovf_next;
                    if (last_j) begin
                        j_cnt <= '0;
                        if (last_i) begin
                            // Result registered on entry to DONE so it is
                            // visible during the DONE cycle.
                            state     <= ST_DONE;
                            out       <= acc_next;
                            ovf       <= ovf_next;
                            out_valid <= 1'b1;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: begin // ST_IDLE and ST_DONE both accept
                    if (accept) begin
                        a_r     <= a;
                        b_r     <= b;
                        sgn_r   <= mode[MODE_SIGNED];
                        acc     <= mac ? acc : c;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        ovf_run <= 1'b0;
                        state   <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iter_mac.sv
// ============================================================================
// Module  : tb_iter_mac
// Purpose : Self-checking bench for iter_mac (N=M=16, W=8, G=4, ACC_W=36).
//           Directed vector table plus hand-written back-to-back and
//           mid-operation reset sequences.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iter_mac;

    localparam int ACC_W = 36;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [ACC_W-1:0] c;
    logic [1:0]       mode;
    logic             mac;
    logic             out_valid;
    logic [ACC_W-1:0] out;
    logic             ovf;

    int applied    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iter_mac #(
        .N   (16),
        .M   (16),
        .W   (8),
        .G   (4),
        .PPM (0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .mode      (mode),
        .mac       (mac),
        .out_valid (out_valid),
        .out       (out),
        .ovf       (ovf)
    );

    typedef struct {
        string            name;
        logic [15:0]      a;
        logic [15:0]      b;
        logic [ACC_W-1:0] c;
        logic             sgn;
        logic             mac;
        logic [ACC_W-1:0] exp_out;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [ACC_W-1:0] act,
                         input logic [ACC_W-1:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply one operation, then check latency (cycle index after the accept
    // edge at which out_valid is seen), result, flag and the 1-cycle strobe.
    task automatic run_op(input vec_t v);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check({v.name, "/ready_timeout"}, 36'(in_ready), 36'd1);
            return;
        end
        a        = v.a;
        b        = v.b;
        c        = v.c;
        mode     = {1'b0, v.sgn};
        mac      = v.mac;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Operands must be ignored once accepted.
        a    = 16'($urandom);
        b    = 16'($urandom);
        c    = 36'({$urandom, $urandom});
        mode = 2'($urandom);
        mac  = 1'($urandom);
        k = 1;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({v.name, "/latency"}, 36'(k), 36'd5);
        check({v.name, "/out"}, out, v.exp_out);
        check({v.name, "/ovf"}, 36'(ovf), 36'(v.exp_ovf));
        @(posedge clk);
        #1;
        check({v.name, "/strobe_width"}, 36'(out_valid), 36'd0);
        check({v.name, "/out_held"}, out, v.exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"u_ffff_ffff", 16'hFFFF, 16'hFFFF, 36'h0, 1'b0, 1'b0, 36'h0_FFFE_0001, 1'b0};
        vecs[1] = '{"s_m1_x_min",  16'hFFFF, 16'h8000, 36'h0, 1'b1, 1'b0, 36'h0_0000_8000, 1'b0};
        vecs[2] = '{"u_ffff_8000", 16'hFFFF, 16'h8000, 36'h0, 1'b0, 1'b0, 36'h0_7FFF_8000, 1'b0};
        vecs[3] = '{"mac_3x4_p10", 16'h0003, 16'h0004, 36'd10, 1'b1, 1'b0, 36'd22, 1'b0};
        vecs[4] = '{"mac_5x5",     16'h0005, 16'h0005, 36'h0, 1'b1, 1'b1, 36'd47, 1'b0};
        vecs[5] = '{"mac_m2x3",    16'hFFFE, 16'h0003, 36'h0, 1'b1, 1'b1, 36'd41, 1'b0};
`ifdef ITER_MAC_SAT_EN
        vecs[6] = '{"ovf_signed",  16'h0001, 16'h0001, 36'h7_FFFF_FFFF, 1'b1, 1'b0, 36'h7_FFFF_FFFF, 1'b1};
`else
        vecs[6] = '{"ovf_signed",  16'h0001, 16'h0001, 36'h7_FFFF_FFFF, 1'b1, 1'b0, 36'h8_0000_0000, 1'b0};
`endif
        vecs[7] = '{"s_min_x_min", 16'h8000, 16'h8000, 36'h0, 1'b1, 1'b0, 36'h0_4000_0000, 1'b0};
        vecs[8] = '{"u_1234_5678", 16'h1234, 16'h5678, 36'd5, 1'b0, 1'b0, 36'h0_0626_0065, 1'b0};
        vecs[9] = '{"s_neg_addend", 16'h7FFF, 16'h0002, 36'hF_FFFF_FFFF, 1'b1, 1'b0, 36'h0_0000_FFFD, 1'b0};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c        = '0;
        mode     = '0;
        mac      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/in_ready",  36'(in_ready),  36'd1);
        check("reset/out_valid", 36'(out_valid), 36'd0);
        check("reset/out",       out,            36'd0);
        check("reset/ovf",       36'(ovf),       36'd0);
        reset_n = 1'b1;

        for (int n = 0; n < 10; n++) begin
            run_op(vecs[n]);
        end

        // Back-to-back: in_valid held for three identical ops. Sample s is
        // taken 1 ns after the (s-1)th edge following the first accept.
        @(negedge clk);
        a        = 16'd3;
        b        = 16'd4;
        c        = 36'd10;
        mode     = 2'b01;
        mac      = 1'b0;
        in_valid = 1'b1;
        check("b2b/idle_ready", 36'(in_ready), 36'd1);
        @(posedge clk);
        for (int s = 1; s <= 16; s++) begin
            #1;
            check($sformatf("b2b/out_valid_s%0d", s), 36'(out_valid),
                  36'((s % 5 == 0) && (s <= 15)));
            check($sformatf("b2b/in_ready_s%0d", s), 36'(in_ready),
                  36'((s % 5 == 0) || (s == 16)));
            if (out_valid)
                check($sformatf("b2b/out_s%0d", s), out, 36'd22);
            if (s == 15)
                in_valid = 1'b0;
            @(posedge clk);
        end

        // Reset during the second RUN cycle aborts the operation.
        @(negedge clk);
        a        = 16'h1234;
        b        = 16'h5678;
        c        = 36'd0;
        mode     = 2'b00;
        mac      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst/async_out",      out,              36'd0);
        check("rst/async_in_ready", 36'(in_ready),    36'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst/in_ready_after", 36'(in_ready), 36'd1);
        check("rst/out_after",      out,           36'd0);
        begin
            int pulses;
            pulses = 0;
            for (int s = 0; s < 8; s++) begin
                if (out_valid) pulses++;
                @(posedge clk);
                #1;
            end
            check("rst/no_out_valid", 36'(pulses), 36'd0);
        end
        // Accumulator must have been cleared: 0 + 1*1 = 1.
        begin
            vec_t v;
            v = '{"rst/acc_cleared", 16'h0001, 16'h0001, 36'h5, 1'b1, 1'b1, 36'd1, 1'b0};
            run_op(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
